// File: rtl/ctrl_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the decoded control-word pipeline chain.
//
// Contents:
//   CTRL_W           default control word width (2-bit ALUOp + 7 flags)
//   *_LSB / *_BIT    bit positions of the individual control fields
//   CTRL_BUBBLE      control word loaded into empty/flushed stages; every
//                    write and memory enable in it is 0
//   STG_EX/MEM/WB    stage indices of the default 3-deep chain
//   ctrl_word_t      packed struct view of the default control word
//   ctrl_has_side_effect()  1 when a word can change architectural state
// ---------------------------------------------------------------------------
package ctrl_pipe_pkg;

  localparam int CTRL_W = 9;

  // Field positions inside the control word.
  localparam int ALUOP_LSB    = 7;
  localparam int ALUOP_W      = 2;
  localparam int ALUSRC_BIT   = 6;
  localparam int REGWRITE_BIT = 5;
  localparam int REGDST_BIT   = 4;
  localparam int MEMREAD_BIT  = 3;
  localparam int MEMWRITE_BIT = 2;
  localparam int MEMTOREG_BIT = 1;
  localparam int BRANCH_BIT   = 0;

  // A bubble must never write a register or touch memory.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'h000;

  // Stage indices of the default ID/EX, EX/MEM, MEM/WB chain.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  localparam int DEPTH_MAX = 8;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               branch;
  } ctrl_word_t;

  // True when the word may alter register file, memory or control flow.
  function automatic logic ctrl_has_side_effect(input logic [CTRL_W-1:0] w);
    return w[REGWRITE_BIT] | w[MEMREAD_BIT] | w[MEMWRITE_BIT] | w[BRANCH_BIT];
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_stage
// One register stage of the control-word pipeline: a valid bit plus a
// WIDTH-bit control word.
//
// Parameters:
//   WIDTH   control word width
//   BUBBLE  word held whenever the stage is not valid
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset -> (valid 0, BUBBLE)
//   load_valid  valid bit offered by the upstream source
//   load_word   word offered by the upstream source
//   hold        keep current contents
//   flush       become a bubble (wins over hold)
//   valid_o     registered valid bit
//   word_o      registered control word
// ---------------------------------------------------------------------------
module ctrl_pipe_stage #(
  parameter int               WIDTH  = 9,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_word,
  input  logic             hold,
  input  logic             flush,
  output logic             valid_o,
  output logic [WIDTH-1:0] word_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] word_q,  word_d;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (flush) begin
      valid_d = 1'b0;
      word_d  = BUBBLE;
    end else if (!hold) begin
      valid_d = load_valid;
      // Mask the incoming word so an invalid stage always carries BUBBLE.
      word_d  = load_valid ? load_word : BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= BUBBLE;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_chain
// DEPTH-stage register chain carrying a decoded control word (and its valid
// bit) from ID through EX, MEM and WB, with per-stage stall and flush.
//
// Optional build macro: CTRL_PIPE_PERF_EN adds saturating stall/bubble
// performance counters; pipeline behaviour is identical either way.
//
// Parameters:
//   WIDTH   control word width (default CTRL_W = 9)
//   DEPTH   number of stages, 1..8 (default 3)
//   BUBBLE  word loaded into invalid/flushed stages
//   CNT_W   performance counter width (CTRL_PIPE_PERF_EN only)
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ctrl_in      control word from the decoder
//   valid_in     ctrl_in carries a real instruction
//   in_ready     stage 0 accepts ctrl_in this cycle (combinational)
//   stall[i]     stage i requests to hold
//   flush[i]     stage i becomes a bubble
//   ctrl_o       stage i word at [i*WIDTH +: WIDTH]
//   valid_o      stage valid bits
//   ctrl_last    word of stage DEPTH-1
//   valid_last   valid bit of stage DEPTH-1
//   stall_cnt    cycles with stage 0 held (CTRL_PIPE_PERF_EN)
//   bubble_cnt   cycles with last stage empty (CTRL_PIPE_PERF_EN)
// ---------------------------------------------------------------------------
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH  = CTRL_W,
  parameter int               DEPTH  = 3,
  parameter logic [WIDTH-1:0] BUBBLE = CTRL_BUBBLE,
  parameter int               CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       ctrl_in,
  input  logic                   valid_in,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH*WIDTH-1:0] ctrl_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [WIDTH-1:0]       ctrl_last,
  output logic                   valid_last
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
`endif
);

  // -------------------------------------------------------------------------
  // Hold chain: a stall anywhere freezes that stage and everything upstream.
  // Built as a descending loop so no packed-vector self-dependency exists.
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0] hold;

  always_comb begin
    hold            = '0;
    hold[DEPTH-1]   = stall[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  assign in_ready = ~hold[0];

  // -------------------------------------------------------------------------
  // Stage array
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_word [DEPTH];
  logic [DEPTH-1:0] load_valid;
  logic [WIDTH-1:0] load_word  [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign load_valid[gi] = valid_in;
      assign load_word[gi]  = ctrl_in;
    end else begin : g_body
      // If the upstream stage is frozen it cannot move forward, so this
      // stage receives a bubble instead of a duplicate of the held word.
      assign load_valid[gi] = stage_valid[gi-1] & ~hold[gi-1];
      assign load_word[gi]  = stage_word[gi-1];
    end

    ctrl_pipe_stage #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid[gi]),
      .load_word  (load_word[gi]),
      .hold       (hold[gi]),
      .flush      (flush[gi]),
      .valid_o    (stage_valid[gi]),
      .word_o     (stage_word[gi])
    );

    assign ctrl_o[gi*WIDTH +: WIDTH] = stage_word[gi];
  end

  assign valid_o    = stage_valid;
  assign ctrl_last  = stage_word[DEPTH-1];
  assign valid_last = stage_valid[DEPTH-1];

`ifdef CTRL_PIPE_PERF_EN
  // -------------------------------------------------------------------------
  // Saturating performance counters
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hold[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!valid_last && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_chain
// Directed bench for ctrl_pipe_chain (WIDTH=9, DEPTH=3, BUBBLE=0, CNT_W=4).
// Counter scenarios are compiled in when CTRL_PIPE_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_chain;

  localparam int W  = 9;
  localparam int D  = 3;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   ctrl_in;
  logic           valid_in;
  logic           in_ready;
  logic [D-1:0]   stall;
  logic [D-1:0]   flush;
  logic [D*W-1:0] ctrl_o;
  logic [D-1:0]   valid_o;
  logic [W-1:0]   ctrl_last;
  logic           valid_last;
`ifdef CTRL_PIPE_PERF_EN
  logic [CW-1:0]  stall_cnt;
  logic [CW-1:0]  bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_pipe_chain #(
    .WIDTH  (W),
    .DEPTH  (D),
    .BUBBLE (9'h000),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_in    (ctrl_in),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .ctrl_o     (ctrl_o),
    .valid_o    (valid_o),
    .ctrl_last  (ctrl_last),
    .valid_last (valid_last)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  function automatic logic [W-1:0] stg(input int i);
    return ctrl_o[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0;
    ctrl_in  = '0;
    stall    = '0;
    flush    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst      = 1'b1;
    valid_in = 1'b1;
    ctrl_in  = 9'h1FF;
    stall    = '0;
    flush    = '0;
    tick();
    tick();
    checks++;
    if (valid_o !== 3'b000) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 000", valid_o);
    end
    checks++;
    if (ctrl_o !== 27'h0) begin
      failures++;
      $display("FAIL reset_words: got %h expected 0", ctrl_o);
    end
    rst     = 1'b0;
    ctrl_in = 9'h1A5;
    tick();
    valid_in = 1'b0;
    ctrl_in  = '0;
    checks++;
    if (stg(0) !== 9'h1A5 || valid_o !== 3'b001) begin
      failures++;
      $display("FAIL reset_first_stage0: got %h/%b expected 1a5/001", stg(0), valid_o);
    end
    tick();
    tick();
    checks++;
    if (ctrl_last !== 9'h1A5 || valid_last !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_last: got %h/%b expected 1a5/1", ctrl_last, valid_last);
    end
    $display("test_reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall();
    logic [W-1:0] exp_last [5];
    logic         exp_vl   [5];
    exp_last = '{9'h000, 9'h000, 9'h002, 9'h003, 9'h004};
    exp_vl   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    valid_in = 1'b1;
    ctrl_in = 9'h001; tick();
    ctrl_in = 9'h002; tick();
    ctrl_in = 9'h003; tick();
    checks++;
    if (ctrl_last !== 9'h001 || valid_last !== 1'b1) begin
      failures++;
      $display("FAIL stall_A_last: got %h/%b expected 001/1", ctrl_last, valid_last);
    end
    ctrl_in = 9'h004;
    stall   = 3'b010;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready);
      end
      tick();
      checks++;
      if (stg(0) !== 9'h003 || stg(1) !== 9'h002 || valid_o !== 3'b011) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got s0=%h s1=%h v=%b expected 003 002 011",
                 c, stg(0), stg(1), valid_o);
      end
    end
    stall = 3'b000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    // ctrl_last after edges 4..8 (edges 4/5 already observed via valid_o).
    for (int e = 2; e < 5; e++) begin
      tick();
      valid_in = 1'b0;
      checks++;
      if (ctrl_last !== exp_last[e] || valid_last !== exp_vl[e]) begin
        failures++;
        $display("FAIL stall_last_seq[%0d]: got %h/%b expected %h/%b",
                 e, ctrl_last, valid_last, exp_last[e], exp_vl[e]);
      end
    end
    $display("test_stall done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall_bubble_sequence();
    // Same stream, checking the two bubbles at the last stage directly.
    do_reset();
    valid_in = 1'b1;
    ctrl_in = 9'h001; tick();
    ctrl_in = 9'h002; tick();
    ctrl_in = 9'h003; tick();
    ctrl_in = 9'h004;
    stall   = 3'b010;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (stg(2) !== 9'h000 || valid_o[2] !== 1'b0) begin
        failures++;
        $display("FAIL stall_bubble[%0d]: got %h/%b expected 000/0", c, stg(2), valid_o[2]);
      end
    end
    stall = 3'b000;
    tick();
    valid_in = 1'b0;
    checks++;
    if (stg(0) !== 9'h004 || stg(1) !== 9'h003 || stg(2) !== 9'h002 || valid_o !== 3'b111) begin
      failures++;
      $display("FAIL stall_resume: got %h %h %h v=%b expected 004 003 002 111",
               stg(0), stg(1), stg(2), valid_o);
    end
    $display("test_stall_bubble_sequence done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush_stall();
    do_reset();
    valid_in = 1'b1;
    ctrl_in = 9'h011; tick();
    ctrl_in = 9'h022; tick();
    ctrl_in = 9'h033; tick();
    ctrl_in = 9'h044;
    stall   = 3'b100;
    flush   = 3'b011;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall_ready: got %b expected 0", in_ready);
    end
    tick();
    checks++;
    if (valid_o !== 3'b100 || stg(0) !== 9'h000 || stg(1) !== 9'h000 || stg(2) !== 9'h011) begin
      failures++;
      $display("FAIL flush_stall: got %h %h %h v=%b expected 000 000 011 100",
               stg(0), stg(1), stg(2), valid_o);
    end
    idle_inputs();
    $display("test_flush_stall done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush_beats_hold();
    do_reset();
    valid_in = 1'b1;
    ctrl_in  = 9'h055;
    tick();
    ctrl_in = 9'h077;
    stall   = 3'b001;
    flush   = 3'b001;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL flush_hold_ready[%0d]: got %b expected 0", c, in_ready);
      end
      tick();
      checks++;
      if (stg(0) !== 9'h000 || valid_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL flush_hold_stage0[%0d]: got %h/%b expected 000/0", c, stg(0), valid_o[0]);
      end
    end
    idle_inputs();
    $display("test_flush_beats_hold done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_invalid_and_midreset();
    do_reset();
    valid_in = 1'b0;
    ctrl_in  = 9'h0FF;
    tick();
    checks++;
    if (stg(0) !== 9'h000 || valid_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL invalid_input: got %h/%b expected 000/0", stg(0), valid_o[0]);
    end
    valid_in = 1'b1;
    ctrl_in = 9'h101; tick();
    ctrl_in = 9'h102; tick();
    ctrl_in = 9'h103; tick();
    checks++;
    if (valid_o !== 3'b111) begin
      failures++;
      $display("FAIL midreset_fill: got %b expected 111", valid_o);
    end
    rst = 1'b1;
    stall = 3'b111;
    flush = 3'b000;
    tick();
    checks++;
    if (valid_o !== 3'b000 || ctrl_o !== 27'h0) begin
      failures++;
      $display("FAIL midreset_clear: got %b %h expected 000 0", valid_o, ctrl_o);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (valid_o !== 3'b000) begin
      failures++;
      $display("FAIL midreset_no_resume: got %b expected 000", valid_o);
    end
    $display("test_invalid_and_midreset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush_all();
    do_reset();
    valid_in = 1'b1;
    ctrl_in = 9'h1E0; tick();
    ctrl_in = 9'h0C1; tick();
    ctrl_in = 9'h062; tick();
    flush = 3'b111;
    tick();
    checks++;
    if (valid_o !== 3'b000 || ctrl_o !== 27'h0) begin
      failures++;
      $display("FAIL flush_all: got %b %h expected 000 0", valid_o, ctrl_o);
    end
    idle_inputs();
    $display("test_flush_all done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [W-1:0] w [8];
    w = '{9'h00F, 9'h1F0, 9'h0AA, 9'h155, 9'h123, 9'h0C3, 9'h13C, 9'h1FF};
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      if (e - 1 < 8) begin
        valid_in = 1'b1;
        ctrl_in  = w[e-1];
      end else begin
        valid_in = 1'b0;
        ctrl_in  = '0;
      end
      tick();
      if (e >= 3) begin
        checks++;
        if (ctrl_last !== w[e-3] || valid_last !== 1'b1) begin
          failures++;
          $display("FAIL b2b_last[%0d]: got %h/%b expected %h/1", e, ctrl_last, valid_last, w[e-3]);
        end
      end
    end
    tick();
    checks++;
    if (valid_last !== 1'b0 || ctrl_last !== 9'h000) begin
      failures++;
      $display("FAIL b2b_drain: got %h/%b expected 000/0", ctrl_last, valid_last);
    end
    $display("test_back_to_back done");
  endtask

`ifdef CTRL_PIPE_PERF_EN
  // -------------------------------------------------------------------------
  task automatic test_perf_counters();
    do_reset();
    checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
      failures++;
      $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt);
    end
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (bubble_cnt !== 4'd4) begin
      failures++;
      $display("FAIL perf_bubble_idle: got %0d expected 4", bubble_cnt);
    end
    do_reset();
    stall = 3'b001;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (stall_cnt !== 4'd5) begin
      failures++;
      $display("FAIL perf_stall5: got %0d expected 5", stall_cnt);
    end
    do_reset();
    stall = 3'b001;
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if (stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL perf_stall_sat: got %0d expected 15", stall_cnt);
    end
    idle_inputs();
    $display("test_perf_counters done");
  endtask
`endif

  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stall();
    test_stall_bubble_sequence();
    test_flush_stall();
    test_flush_beats_hold();
    test_invalid_and_midreset();
    test_flush_all();
    test_back_to_back();
`ifdef CTRL_PIPE_PERF_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
